// File: rtl/chan_mux_pkg.sv
// Shared types and helpers for the chan_mux_rr channel selector.
package chan_mux_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_RR     = 1'b1
    } mux_mode_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Round-robin pointer successor. Wraps N-1 back to 0 for any N, not just powers of two.
    function automatic int rr_next_ptr(input int idx, input int n);
        int nxt;
        nxt = idx + 1;
        if (nxt >= n) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/chan_mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching ptr, ptr+1, ... modulo N. The pointer register lives in the caller.
module rr_arbiter
    import chan_mux_pkg::*;
#(
    parameter int N = 32,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    logic [SW:0] pos_s;
    logic        hit_s;

    // Walk the N candidate positions in priority order and latch the first requester.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        pos_s   = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s = {1'b0, ptr} + (SW+1)'(k);
            pos_s = (pos_s >= (SW+1)'(N)) ? (pos_s - (SW+1)'(N)) : pos_s;
            hit_s = en & ~any & (pos_s < (SW+1)'(N)) & req[pos_s[SW-1:0]];
            gnt[pos_s[SW-1:0]] = gnt[pos_s[SW-1:0]] | hit_s;
            gnt_idx = hit_s ? pos_s[SW-1:0] : gnt_idx;
            any     = any | hit_s;
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel, W-bit selector with a single registered output slot and
// valid/ready flow control. DIRECT mode picks channel s; ROUND_ROBIN mode
// arbitrates fairly among valid channels.
// Optional feature: define CHAN_MUX_PARITY_EN to add the registered
// out_parity port (XOR-reduce of the accepted word).
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 4,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mode,
    input  logic [SW-1:0]  s,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
`ifdef CHAN_MUX_PARITY_EN
    ,
    output logic           out_parity
`endif
);

    slot_state_t     state_r;
    logic [SW-1:0]   ptr_r;
    logic [W-1:0]    out_data_r;
    logic [SW-1:0]   out_chan_r;
    logic            out_valid_r;

    logic            mode_rr_s;
    logic            can_load_s;
    logic [N-1:0]    rr_gnt_s;
    logic [SW-1:0]   rr_idx_s;
    logic            rr_any_s;
    logic [N-1:0]    dir_gnt_s;
    logic [N-1:0]    gnt_s;
    logic [SW-1:0]   sel_idx_s;
    logic [W-1:0]    sel_data_s;
    logic            xfer_s;

    assign mode_rr_s  = (mux_mode_t'(mode) == MODE_RR);
    // The slot can take a word when empty, or when full and draining this cycle.
    assign can_load_s = (state_r == SLOT_EMPTY) || out_ready;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (ptr_r),
        .en      (can_load_s & mode_rr_s),
        .gnt     (rr_gnt_s),
        .gnt_idx (rr_idx_s),
        .any     (rr_any_s)
    );

    // DIRECT grant: an index of N or above matches no channel, so it never grants.
    always_comb begin
        dir_gnt_s = '0;
        for (int i = 0; i < N; i++) begin
            dir_gnt_s[i] = (s == SW'(i)) & in_valid[i] & can_load_s & ~mode_rr_s;
        end
    end

    assign gnt_s     = mode_rr_s ? rr_gnt_s : dir_gnt_s;
    assign sel_idx_s = mode_rr_s ? rr_idx_s : s;
    assign xfer_s    = mode_rr_s ? rr_any_s : (|dir_gnt_s);
    // No channel may see ready while the block is held in reset.
    assign in_ready  = gnt_s & {N{reset}};

    // AND-OR mux of the granted channel's word.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < N; i++) begin
            sel_data_s = sel_data_s | (in_data[i*W +: W] & {W{sel_idx_s == SW'(i)}});
        end
    end

    // Output slot FSM: load on transfer, drain to EMPTY when accepted with no refill, hold on stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= SLOT_EMPTY;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
        end else if (xfer_s) begin
            state_r     <= SLOT_FULL;
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_chan_r  <= sel_idx_s;
        end else begin
            case (state_r)
                SLOT_EMPTY: begin
                    state_r     <= SLOT_EMPTY;
                    out_valid_r <= 1'b0;
                end
                SLOT_FULL: begin
                    if (out_ready) begin
                        state_r     <= SLOT_EMPTY;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= SLOT_FULL;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= SLOT_EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer advances past the winner only on RR transfers; kept across mode switches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (xfer_s && mode_rr_s) begin
            ptr_r <= SW'(rr_next_ptr(int'(rr_idx_s), N));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

`ifdef CHAN_MUX_PARITY_EN
    logic parity_r;

    function automatic logic word_parity(input logic [W-1:0] word);
        return ^word;
    endfunction

    // Parity travels with the data word and is held whenever the slot is not reloaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_r <= 1'b0;
        end else if (xfer_s) begin
            parity_r <= word_parity(sel_data_s);
        end else begin
            parity_r <= parity_r;
        end
    end

    assign out_parity = parity_r;
`endif

endmodule

// File: doc/chan_mux_rr.md
Name: chan_mux_rr

Overview:
- Parametrised N-channel, W-bit selector. It is the registered, flow-controlled successor to the fixed 32:1 4-bit combinational mux tree.
- Two modes: DIRECT, where the external index picks the channel, and ROUND_ROBIN, where the block arbitrates fairly among valid channels.
- Output is a single registered slot with valid/ready handshake, so it can sit between pipeline stages or feed shared buses and display paths.

Parameters:
- N, 32, number of input channels (2..64).
- W, 4, data width per channel.
- SW, $clog2(N), select/index width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  0 = DIRECT, 1 = ROUND_ROBIN; sampled every cycle.
- s  input  SW  channel index in DIRECT mode.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel accept (one-hot or zero; combinational).
- out_data  output  W  registered selected data.
- out_chan  output  SW  index of the channel that supplied out_data.
- out_valid  output  1  output slot holds data.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (reset low, asynchronous): out_valid=0, out_data=0, out_chan=0, RR pointer ptr=0. in_ready is all zero while reset is asserted.
- Output slot FSM has two states, EMPTY and FULL.
  - can_load = EMPTY | (FULL & out_ready).
- Grant, combinational, at most one bit set:
  - DIRECT: grant[s] = in_valid[s] & can_load. If s >= N, there is no grant.
  - ROUND_ROBIN: grant goes to the first i with in_valid[i], searching ptr, ptr+1, ... wrapping modulo N, gated by can_load.
- in_ready = grant. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer: at the next edge, out_data = channel data, out_chan = i, out_valid = 1 (state FULL).
- Pointer update: in ROUND_ROBIN, on a transfer, ptr = (i+1) mod N. Wrap from N-1 goes to 0, including non-power-of-2 N. ptr is unchanged in DIRECT mode and on cycles with no transfer.
- Drain without refill: out_valid & out_ready with no new grant -> EMPTY next cycle. out_data and out_chan keep their last values.
- Simultaneous drain + load: the slot is overwritten in the same edge and out_valid stays 1. Throughput is 1 transfer/cycle.
- Stall: out_valid & !out_ready -> out_data and out_chan are held stable and in_ready is all zero.
- Latency is 1 cycle from accepted input to out_valid.
- A mode change takes effect in the same cycle's grant. ptr is retained across mode switches.
- Reset asserted mid-transfer clears the slot immediately; no partial data survives.

Optional Feature:
- Macro: CHAN_MUX_PARITY_EN.
- When defined: adds output port out_parity (1 bit). It is registered alongside out_data and equals the XOR-reduce of the accepted word. It resets to 0 and is held during stalls.
- When undefined: the port is absent and there is no parity logic.

Decomposition:
- Package chan_mux_pkg contains:
  - typedef enum logic {MODE_DIRECT=1'b0, MODE_RR=1'b1} mux_mode_t;
  - localparam function for the RR next-pointer wrap.
- Sub-module rr_arbiter, parametrised on N.
  - Inputs: req[N], ptr[SW], en.
  - Outputs: gnt[N] (one-hot), gnt_idx[SW], any.
  - Purely combinational; the pointer register lives in chan_mux_rr.

Test Plan:
- Reset: assert reset low with in_valid all ones -> out_valid=0, out_data=0, out_chan=0, in_ready=0. Release reset with mode=RR -> next cycle out_chan=0.
- DIRECT: mode=0, s=17, in_data ch17=4'hA, in_valid[17]=1, out_ready=1 -> in_ready=1<<17; next cycle out_data=A, out_chan=17. With s=17 and in_valid[17]=0 -> no grant, out_valid drops.
- RR fairness: N=32, channels 3, 9, 31 held valid, out_ready=1 -> grant sequence 3, 9, 31, 3 (wrap), one per cycle, out_valid continuous.
- Stall: FULL with out_chan=9 and out_ready=0 for 5 cycles -> out_data and out_chan stable, in_ready=0, ptr unchanged. out_ready=1 -> next grant is 31.
- Non-power-of-2: N=5, only channel 4 valid then only channel 0 -> ptr wraps 4 -> 0. In DIRECT mode, s=6 never grants.
- Parity (CHAN_MUX_PARITY_EN): accept 4'b1011 -> out_parity=1; accept 4'b1001 -> out_parity=0.
